// File: rtl/f_nextpc_pkg.sv
// f_nextpc_pkg: shared constants and types for the fetch next-PC generator.
//   PC_W           word-address width of every PC in the fetch path
//   pc_t           13-bit word address
//   BN_*           branch_number encodings carried in the F/D register
//   CNT_WT/CNT_MAX 2-bit BTB confidence counter: predict taken at >= CNT_WT
package f_nextpc_pkg;

  localparam int PC_W = 13;

  typedef logic [PC_W-1:0] pc_t;

  localparam logic [1:0] BN_NONE  = 2'b00;
  localparam logic [1:0] BN_SLOT1 = 2'b01;
  localparam logic [1:0] BN_SLOT2 = 2'b10;

  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_MAX = 2'd3;

endpackage

// File: rtl/f_nextpc_if.sv
// f_nextpc_if: control/redirect/training inputs and F/D outputs of f_nextpc.
//   master: the surrounding core (drives stall, redirects, BTB training;
//           receives fetch_pc and the F/D fields)
//   slave : f_nextpc itself
interface f_nextpc_if;
  import f_nextpc_pkg::*;

  logic       stall;
  logic       d_redirect;
  pc_t        d_redirect_pc;
  logic       e_redirect;
  pc_t        e_redirect_pc;
  logic       upd_en;
  pc_t        upd_pc;
  pc_t        upd_target;
  logic       upd_taken;
  pc_t        fetch_pc;
  pc_t        pc1;
  pc_t        pc2;
  pc_t        pc_predicted;
  logic [1:0] branch_number;
  logic       fetch_valid;

  modport master (
    output stall, d_redirect, d_redirect_pc, e_redirect, e_redirect_pc,
           upd_en, upd_pc, upd_target, upd_taken,
    input  fetch_pc, pc1, pc2, pc_predicted, branch_number, fetch_valid
  );

  modport slave (
    input  stall, d_redirect, d_redirect_pc, e_redirect, e_redirect_pc,
           upd_en, upd_pc, upd_target, upd_taken,
    output fetch_pc, pc1, pc2, pc_predicted, branch_number, fetch_valid
  );

endinterface

// File: rtl/f_btb.sv
// f_btb: direct-mapped branch target buffer, two lookup ports, one training port.
//   clk, rst             clock, synchronous active-high reset (clears valid/counters)
//   rd_pc1/rd_pc2        lookup addresses (fetch slot 1 and slot 2)
//   hit1/hit2, tgt1/tgt2 lookup result: valid, tag match and counter >= CNT_WT
//   upd_en/upd_pc/upd_target/upd_taken  training from execute
// Lookups read the registered array, so a same-cycle update is not visible.
module f_btb import f_nextpc_pkg::*; #(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  pc_t  rd_pc1,
  input  pc_t  rd_pc2,
  output logic hit1,
  output logic hit2,
  output pc_t  tgt1,
  output pc_t  tgt2,
  input  logic upd_en,
  input  pc_t  upd_pc,
  input  pc_t  upd_target,
  input  logic upd_taken
);

  localparam int TAG_W = PC_W - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]             cnt_q [BTB_ENTRIES];
  logic [1:0]             cnt_d [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  pc_t                    tgt_q [BTB_ENTRIES];
  pc_t                    tgt_d [BTB_ENTRIES];

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
    else    return (c == 2'd0)    ? 2'd0    : c - 2'd1;
  endfunction

  logic [IDX_W-1:0] idx1, idx2, upd_idx;
  logic [TAG_W-1:0] rtag1, rtag2, upd_tag;
  logic             upd_hit;

  assign idx1    = rd_pc1[IDX_W-1:0];
  assign idx2    = rd_pc2[IDX_W-1:0];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign rtag1   = rd_pc1[PC_W-1:IDX_W];
  assign rtag2   = rd_pc2[PC_W-1:IDX_W];
  assign upd_tag = upd_pc[PC_W-1:IDX_W];

  assign hit1 = valid_q[idx1] && (tag_q[idx1] == rtag1) && (cnt_q[idx1] >= CNT_WT);
  assign hit2 = valid_q[idx2] && (tag_q[idx2] == rtag2) && (cnt_q[idx2] >= CNT_WT);
  assign tgt1 = tgt_q[idx1];
  assign tgt2 = tgt_q[idx2];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_en) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = sat_cnt(cnt_q[upd_idx], upd_taken);
        // A not-taken outcome says nothing about the target; keep the old one.
        if (upd_taken) tgt_d[upd_idx] = upd_target;
      end else if (upd_taken) begin
        // Allocate straight at the weakly-taken threshold so it predicts next time.
        valid_d[upd_idx] = 1'b1;
        cnt_d[upd_idx]   = CNT_WT;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) cnt_q[i] <= 2'd0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/f_nextpc.sv
// f_nextpc: fetch-stage next-PC generator for the dual-issue core.
//   clk, rst  clock, synchronous active-high reset (overrides everything)
//   bus       f_nextpc_if.slave: stall, decode/execute redirects, BTB training
//             in; fetch_pc and the F/D fields pc1, pc2, pc_predicted,
//             branch_number, fetch_valid out.
// Each cycle fetches the pair (pc_q, pc_q+1); the F/D fields describe the pair
// fetched in the previous cycle, aligned with synchronous imem read data.
module f_nextpc import f_nextpc_pkg::*; #(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input logic       clk,
  input logic       rst,
  f_nextpc_if.slave bus
);

  pc_t        pc_q, pc_d;
  pc_t        pc1_q, pc1_d;
  pc_t        pc2_q, pc2_d;
  pc_t        pred_q, pred_d;
  logic [1:0] bn_q, bn_d;
  logic       fv_q, fv_d;

  pc_t        pc_plus1;
  pc_t        next_pred;
  logic [1:0] bn;
  logic       hit1, hit2;
  pc_t        tgt1, tgt2;

  assign pc_plus1 = pc_q + 13'd1;

  f_btb #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_pc1     (pc_q),
    .rd_pc2     (pc_plus1),
    .hit1       (hit1),
    .hit2       (hit2),
    .tgt1       (tgt1),
    .tgt2       (tgt2),
    .upd_en     (bus.upd_en),
    .upd_pc     (bus.upd_pc),
    .upd_target (bus.upd_target),
    .upd_taken  (bus.upd_taken)
  );

  // Slot 1 wins: a taken branch in slot 1 makes slot 2 dead.
  always_comb begin
    next_pred = pc_q + 13'd2;
    bn        = BN_NONE;
    if (hit1) begin
      next_pred = tgt1;
      bn        = BN_SLOT1;
    end else if (hit2) begin
      next_pred = tgt2;
      bn        = BN_SLOT2;
    end
  end

  // Execute redirects are older than decode ones, so they win; a redirect
  // also beats stall because the stalled pair is being squashed anyway.
  always_comb begin
    pc_d   = pc_q;
    pc1_d  = pc1_q;
    pc2_d  = pc2_q;
    pred_d = pred_q;
    bn_d   = bn_q;
    fv_d   = fv_q;
    if (bus.e_redirect) begin
      pc_d = bus.e_redirect_pc;
      fv_d = 1'b0;
    end else if (bus.d_redirect) begin
      pc_d = bus.d_redirect_pc;
      fv_d = 1'b0;
    end else if (!bus.stall) begin
      pc1_d  = pc_q;
      pc2_d  = pc_plus1;
      pred_d = next_pred;
      bn_d   = bn;
      fv_d   = 1'b1;
      pc_d   = next_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= 13'd0;
      pc1_q  <= 13'd0;
      pc2_q  <= 13'd1;
      pred_q <= 13'd2;
      bn_q   <= BN_NONE;
      fv_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pc1_q  <= pc1_d;
      pc2_q  <= pc2_d;
      pred_q <= pred_d;
      bn_q   <= bn_d;
      fv_q   <= fv_d;
    end
  end

  assign bus.fetch_pc      = pc_q;
  assign bus.pc1           = pc1_q;
  assign bus.pc2           = pc2_q;
  assign bus.pc_predicted  = pred_q;
  assign bus.branch_number = bn_q;
  assign bus.fetch_valid   = fv_q;

endmodule
